data_sram_slave: RTL and testbench

//  Memory-side responder for the CPU data-SRAM-like request interface: accepts
//  req/addr handshakes from the EXE stage, queues them in order, and returns data_ok/rdata

---
 rtl/sram_pkg.sv | 31 +++
 rtl/sram_req_fifo.sv | 47 ++++
 rtl/data_sram_slave.sv | 106 ++++++++++
 tb/tb_data_sram_slave.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared request type, defaults and byte-merge helper for the data-SRAM responder.
package sram_pkg;
  localparam int WORD_BYTES  = 4;
  localparam int ADDR_W_DEF  = 12;
  localparam int Q_DEPTH_DEF = 4;
  localparam int LAT_DEF     = 2;
  // Wide enough for any word index carved out of a 32-bit byte address.
  localparam int IDX_W       = 30;

  typedef struct packed {
    logic                      wr;
    logic [IDX_W-1:0]          idx;
    logic [WORD_BYTES-1:0]     wstrb;
    logic [8*WORD_BYTES-1:0]   wdata;
  } sram_req_t;

  localparam int REQ_W = $bits(sram_req_t);

  function automatic logic [8*WORD_BYTES-1:0] byte_merge(
    input logic [8*WORD_BYTES-1:0] old_word,
    input logic [8*WORD_BYTES-1:0] new_word,
    input logic [WORD_BYTES-1:0]   strb
  );
    logic [8*WORD_BYTES-1:0] merged;
    merged = old_word;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction
endpackage

// File: rtl/sram_req_fifo.sv
// Synchronous FIFO holding outstanding requests; head is presented combinationally.
module sram_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= din;
  end

  assign dout  = store[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/data_sram_slave.sv
// In-order data-SRAM responder: queues accepted requests and retires the head
// LAT cycles after it becomes head, with registered data_ok/rdata.
module data_sram_slave
  import sram_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int Q_DEPTH = Q_DEPTH_DEF,
  parameter int LAT     = LAT_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  input  logic        stall,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  localparam int CW   = $clog2(Q_DEPTH) + 1;
  localparam int HC_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [HC_W-1:0] HC_LAST  = HC_W'(LAT - 1);
  // An entry accepted into an empty queue counts its accept cycle as head cycle 0.
  localparam logic [HC_W-1:0] HC_FIRST = HC_W'((LAT > 1) ? 1 : 0);

  sram_req_t         in_req;
  sram_req_t         head_req;
  sram_req_t         ret_req;
  logic [REQ_W-1:0]  head_bits;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [HC_W-1:0]   head_cnt;
  logic              accept;
  logic              bypass;
  logic              retire;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] ret_idx;
  logic [31:0]       mem [2**ADDR_W];
  logic              unused_bits;

  assign addr_ok = resetn & ~stall & (count < CW'(Q_DEPTH));
  assign accept  = req & addr_ok;

  always_comb begin
    in_req       = '0;
    in_req.wr    = wr;
    in_req.idx   = IDX_W'(addr[ADDR_W+1:2]);
    in_req.wstrb = wstrb;
    in_req.wdata = wdata;
  end

  // With LAT=1 a request into an empty queue must retire on its accept edge.
  assign bypass = (LAT == 1) & accept & empty;
  assign retire = bypass | (resetn & ~empty & (head_cnt == HC_LAST));
  assign push   = accept & ~bypass;
  assign pop    = retire & ~bypass;

  sram_req_fifo #(
    .DEPTH (Q_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    (in_req),
    .dout   (head_bits),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  always_comb begin
    head_req = sram_req_t'(head_bits);
    ret_req  = bypass ? in_req : head_req;
    ret_idx  = ret_req.idx[ADDR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn)              head_cnt <= '0;
    else if (accept && empty) head_cnt <= HC_FIRST;
    else if (retire)          head_cnt <= '0;
    else if (!empty)          head_cnt <= head_cnt + HC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (retire && ret_req.wr)
      mem[ret_idx] <= byte_merge(mem[ret_idx], ret_req.wdata, ret_req.wstrb);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_ok <= 1'b0;
      rdata   <= '0;
    end else begin
      data_ok <= retire;
      rdata   <= (retire && !ret_req.wr) ? mem[ret_idx] : '0;
    end
  end

  assign unused_bits = ^{addr[31:ADDR_W+2], addr[1:0], head_req.idx[IDX_W-1:ADDR_W], full};
endmodule

// File: tb/tb_data_sram_slave.sv
// Randomized bench for data_sram_slave against a queue-and-array reference model.
module tb_data_sram_slave;
  localparam int ADDR_W  = 12;
  localparam int Q_DEPTH = 4;
  localparam int LAT     = 2;
  localparam int NIDX    = 16;

  logic        clk = 1'b0;
  logic        resetn, req, wr, stall;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  data_sram_slave #(.ADDR_W(ADDR_W), .Q_DEPTH(Q_DEPTH), .LAT(LAT)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .wr      (wr),
    .addr    (addr),
    .wstrb   (wstrb),
    .wdata   (wdata),
    .stall   (stall),
    .addr_ok (addr_ok),
    .data_ok (data_ok),
    .rdata   (rdata)
  );

  always #5 clk = ~clk;

  // Each accepted request carries the cycle its data_ok must appear in.
  typedef struct {
    bit        wr;
    int        idx;
    bit [3:0]  strb;
    bit [31:0] data;
    int        ok;
  } pend_t;

  pend_t      pend[$];
  bit [31:0]  mem_m [int];
  int         cyc, last_ok_cyc;
  int         checks, errors;
  int         dut_pulses, model_pulses;
  logic       got_ok, got_aok;
  logic [31:0] got_rd;
  bit         accepted, aok_low_seen;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic eval_cycle();
    bit          exp_ok = 1'b0;
    bit          exp_aok;
    logic [31:0] exp_rd = '0;
    int          ok_at;
    pend_t       e;
    got_ok  = data_ok;
    got_aok = addr_ok;
    got_rd  = rdata;
    if (got_ok === 1'b1) dut_pulses++;
    if (req && got_aok !== 1'b1) aok_low_seen = 1'b1;
    if (pend.size() != 0 && pend[0].ok == cyc) begin
      e = pend.pop_front();
      exp_ok = 1'b1;
      model_pulses++;
      if (e.wr) begin
        bit [31:0] w = mem_m[e.idx];
        for (int i = 0; i < 4; i++) if (e.strb[i]) w[8*i +: 8] = e.data[8*i +: 8];
        mem_m[e.idx] = w;
      end else begin
        exp_rd = mem_m[e.idx];
      end
    end
    check_val("data_ok", got_ok, exp_ok);
    check_val("rdata", got_rd, exp_rd);
    exp_aok = resetn && !stall && (pend.size() < Q_DEPTH);
    check_val("addr_ok", got_aok, exp_aok);
    accepted = req && exp_aok;
    if (accepted) begin
      ok_at = cyc + LAT;
      if (last_ok_cyc + LAT > ok_at) ok_at = last_ok_cyc + LAT;
      e.wr = wr; e.idx = int'(addr[ADDR_W+1:2]); e.strb = wstrb; e.data = wdata; e.ok = ok_at;
      pend.push_back(e);
      last_ok_cyc = ok_at;
    end
    if (!resetn) begin
      pend.delete();
      last_ok_cyc = -100;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] mk_addr(input int idx);
    logic [31:0] a = $urandom;
    a[ADDR_W+1:2] = ADDR_W'(idx);
    return a;
  endfunction

  task automatic send(input bit w, input int idx, input logic [3:0] s, input logic [31:0] d, input int stall_pct);
    int n = 0;
    req = 1'b1; wr = w; addr = mk_addr(idx); wstrb = s; wdata = d;
    do begin
      stall = ($urandom_range(99) < stall_pct);
      tick();
      n++;
    end while (!accepted && n < 60);
    check_val("send_accept", accepted, 1'b1);
    req = 1'b0; stall = 1'b0; wr = $urandom; addr = $urandom; wstrb = $urandom; wdata = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    int n = 0;
    while (pend.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check_val("drain", pend.size(), 0);
  endtask

  initial begin
    checks = 0; errors = 0; dut_pulses = 0; model_pulses = 0;
    last_ok_cyc = -100; aok_low_seen = 1'b0;
    resetn = 1'b0; req = 1'b0; stall = 1'b0; wr = 1'b0; addr = '0; wstrb = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    cyc = 0;
    tick();
    check_val("rst_aok", got_aok, 1'b0);
    resetn = 1'b1;
    tick();

    // Preload: full-word writes so every later read has a known value.
    for (int i = 0; i < NIDX; i++) begin
      logic [31:0] v = $urandom;
      if (i == 5) v = 32'h1122_3344;
      if (i == 8) v = 32'h0;
      send(1'b1, i, 4'hF, v, 0);
    end
    send(1'b1, 40, 4'hF, 32'h5A5A_0F0F, 0);
    drain();

    // Single read into an empty queue.
    send(1'b0, 5, 4'h0, 32'h0, 0);
    tick();
    check_val("t1_ok_t1", got_ok, 1'b0);
    tick();
    check_val("t1_ok_t2", got_ok, 1'b1);
    check_val("t1_rd_t2", got_rd, 32'h1122_3344);
    tick();
    check_val("t1_ok_t3", got_ok, 1'b0);
    drain();

    // Partial write followed immediately by a read of the same word.
    send(1'b1, 8, 4'b0010, 32'hAABB_CCDD, 0);
    send(1'b0, 8, 4'h0, 32'h0, 0);
    tick();
    check_val("t2_wok", got_ok, 1'b1);
    check_val("t2_wrd", got_rd, 32'h0);
    tick();
    check_val("t2_gap", got_ok, 1'b0);
    tick();
    check_val("t2_rok", got_ok, 1'b1);
    check_val("t2_rd", got_rd, 32'h0000_CC00);
    drain();

    // Back-to-back reads until the queue fills.
    aok_low_seen = 1'b0;
    for (int i = 0; i < 12; i++) send(1'b0, i, 4'h0, 32'h0, 0);
    check_val("t3_backpressure", aok_low_seen, 1'b1);
    drain();

    // Stall holds off acceptance.
    req = 1'b1; wr = 1'b0; addr = mk_addr(3); stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("t4_stall_aok", got_aok, 1'b0);
      check_val("t4_stall_ok", got_ok, 1'b0);
    end
    send(1'b0, 8, 4'h0, 32'h0, 0);
    tick();
    tick();
    check_val("t4_ok", got_ok, 1'b1);
    check_val("t4_rd", got_rd, 32'h0000_CC00);
    drain();

    // Reset with a write in flight: it must never reach memory.
    send(1'b1, 40, 4'hF, 32'hDEAD_BEEF, 0);
    resetn = 1'b0; req = 1'b1; wr = 1'b1; addr = mk_addr(41); wstrb = 4'hF;
    tick();
    check_val("t5_rst_aok", got_aok, 1'b0);
    resetn = 1'b1; req = 1'b0;
    tick();
    check_val("t5_post_ok", got_ok, 1'b0);
    check_val("t5_post_aok", got_aok, 1'b1);
    idle(4);
    send(1'b0, 40, 4'h0, 32'h0, 0);
    tick();
    tick();
    check_val("t5_ok", got_ok, 1'b1);
    check_val("t5_rd", got_rd, 32'h5A5A_0F0F);
    drain();

    // Random mixed stream with random stall, then read back the whole image.
    for (int i = 0; i < 40; i++) begin
      send(1'($urandom), int'($urandom_range(NIDX-1)), 4'($urandom), $urandom, 30);
      if ($urandom_range(3) == 0) idle(int'($urandom_range(2)));
    end
    drain();
    for (int i = 0; i < NIDX; i++) send(1'b0, i, 4'h0, 32'h0, 0);
    drain();
    idle(2);

    check_val("pulses", dut_pulses, model_pulses);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
